pc_fetch: RTL

Instruction-fetch front end of the pipelined MIPS core: owns the fetch PC, issues requests to instruction memory over a req/ack handshake, and buffers fetched words for the F/D register. It is the consumer of the D-stage branch comparator result: it receives the taken/not-taken decision plus jump/branch operands and redirects fetch after the branch delay slot, discarding any wrong-path words already fetched.

---
 rtl/pc_fetch_if.sv | 11 +
 rtl/pc_fetch.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_if.sv
// Instruction-memory request/acknowledge bus between the fetch unit and imem.
// The fetch unit is the master; it holds req/addr stable until ack.
interface pc_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/pc_fetch.sv
// Fetch front end: owns the fetch PC, issues imem requests, buffers words for F/D
// (output buffer plus one skid entry) and redirects after the branch delay slot.
module pc_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic              clk,
  input  logic              reset,
  pc_fetch_if.master        imem,
  output logic              if_valid,
  output logic [31:0]       if_instr,
  output logic [31:0]       if_pc,
  input  logic              if_ready,
  input  logic              d_fire,
  input  logic              br_en,
  input  logic              cmp_y,
  input  logic [31:0]       br_pc,
  input  logic [15:0]       br_off,
  input  logic              j_en,
  input  logic [25:0]       j_idx,
  input  logic              jr_en,
  input  logic [31:0]       jr_tgt
);

  typedef enum logic {S_REQ, S_PARK} state_e;

  state_e      state_q, state_d;
  logic [31:0] fpc_q, fpc_d;
  logic        ov_q, ov_d;
  logic [31:0] oinstr_q, oinstr_d, opc_q, opc_d;
  logic        sv_q, sv_d;
  logic [31:0] sinstr_q, sinstr_d, spc_q, spc_d;
  logic        pv_q, pv_d;
  logic [31:0] ptgt_q, ptgt_d, pds_q, pds_d;
  logic        disc_q, disc_d;
  logic [31:0] rtgt_q, rtgt_d;

  function automatic logic [31:0] calc_target(
    input logic [31:0] pc, input logic [15:0] off, input logic je,
    input logic [25:0] idx, input logic jre, input logic [31:0] rt);
    logic signed [31:0] off_w;
    logic [31:0]        ds;
    logic [31:0]        t;
    off_w = {{14{off[15]}}, off, 2'b00};
    ds    = pc + 32'd4;
    if (jre)
      t = rt;
    else if (je)
      t = {ds[31:28], idx, 2'b00};
    else
      t = ds + $unsigned(off_w);
    return t & 32'hFFFF_FFFC;
  endfunction

  logic [31:0] ds_pc, tgt;
  logic        redirect, ack_fire, buf_free, word_keep;
  logic        ds_in_buf, ds_in_skid, ds_in_flight, ds_older;
  logic        kill_skid, kill_flight, bypass, hold_pend;

  assign ds_pc    = br_pc + 32'd4;
  assign tgt      = calc_target(br_pc, br_off, j_en, j_idx, jr_en, jr_tgt);
  assign redirect = d_fire & (jr_en | j_en | (br_en & cmp_y));
  assign ack_fire = (state_q == S_REQ) & imem.imem_ack;
  assign buf_free = !ov_q | if_ready;

  // Where the delay slot sits decides what is younger and must be thrown away.
  assign ds_in_buf    = ov_q & (opc_q == ds_pc);
  assign ds_in_skid   = sv_q & (spc_q == ds_pc);
  assign ds_in_flight = (state_q == S_REQ) & !disc_q & (fpc_q == ds_pc);
  assign ds_older     = ds_in_buf | ds_in_skid;
  assign kill_skid    = redirect & ds_in_buf;
  assign kill_flight  = redirect & ds_older & (state_q == S_REQ);
  assign bypass       = redirect & ds_in_flight & ack_fire;
  assign hold_pend    = redirect & !ds_older & !bypass;
  assign word_keep    = ack_fire & !disc_q & !kill_flight;

  always_comb begin
    state_d  = state_q;
    fpc_d    = fpc_q;
    ov_d     = ov_q;
    oinstr_d = oinstr_q;
    opc_d    = opc_q;
    sv_d     = sv_q;
    sinstr_d = sinstr_q;
    spc_d    = spc_q;
    pv_d     = pv_q;
    ptgt_d   = ptgt_q;
    pds_d    = pds_q;
    disc_d   = disc_q;
    rtgt_d   = rtgt_q;

    if (hold_pend) begin
      pv_d   = 1'b1;
      ptgt_d = tgt;
      pds_d  = ds_pc;
    end else if (redirect) begin
      pv_d = 1'b0;
    end

    if (ack_fire) begin
      disc_d = 1'b0;
      if (kill_flight | bypass) begin
        fpc_d = tgt;
      end else if (disc_q) begin
        fpc_d = rtgt_q;
      end else if (pv_q && (fpc_q == pds_q)) begin
        fpc_d = ptgt_q;
        if (!hold_pend) pv_d = 1'b0;
      end else begin
        fpc_d = fpc_q + 32'd4;
      end
    end else if (kill_flight) begin
      // The request cannot be withdrawn; absorb its ack and jump afterwards.
      disc_d = 1'b1;
      rtgt_d = tgt;
    end else if (redirect & ds_older) begin
      fpc_d = tgt;
    end

    if (kill_skid) sv_d = 1'b0;
    if (buf_free) begin
      if (sv_q && !kill_skid) begin
        ov_d     = 1'b1;
        oinstr_d = sinstr_q;
        opc_d    = spc_q;
        sv_d     = 1'b0;
      end else if (word_keep) begin
        ov_d     = 1'b1;
        oinstr_d = imem.imem_rdata;
        opc_d    = fpc_q;
      end else begin
        ov_d = 1'b0;
      end
    end else if (word_keep) begin
      sv_d     = 1'b1;
      sinstr_d = imem.imem_rdata;
      spc_d    = fpc_q;
    end

    case (state_q)
      S_REQ:   if (sv_d)  state_d = S_PARK;
      S_PARK:  if (!sv_d) state_d = S_REQ;
      default: state_d = S_REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_REQ;
      fpc_q    <= RESET_PC;
      ov_q     <= 1'b0;
      oinstr_q <= 32'd0;
      opc_q    <= 32'd0;
      sv_q     <= 1'b0;
      pv_q     <= 1'b0;
      disc_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      fpc_q    <= fpc_d;
      ov_q     <= ov_d;
      oinstr_q <= oinstr_d;
      opc_q    <= opc_d;
      sv_q     <= sv_d;
      pv_q     <= pv_d;
      disc_q   <= disc_d;
    end
  end

  // Payload registers are only meaningful under their valid flags.
  always_ff @(posedge clk) begin
    sinstr_q <= sinstr_d;
    spc_q    <= spc_d;
    ptgt_q   <= ptgt_d;
    pds_q    <= pds_d;
    rtgt_q   <= rtgt_d;
  end

  assign imem.imem_req  = (state_q == S_REQ);
  assign imem.imem_addr = fpc_q;
  assign if_valid       = ov_q;
  assign if_instr       = oinstr_q;
  assign if_pc          = opc_q;

endmodule
